// File: rtl/arb_mux_pkg.sv
// arb_mux_pkg -- shared types and sizing helpers for the arb_mux block.
//   arb_mux_state_e : transaction FSM states
//   id_width()      : width of a master index (at least one bit)
//   cnt_width()     : width of the timeout counter able to hold TIMEOUT
package arb_mux_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    RELEASE  = 2'd3
  } arb_mux_state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/arb_mux_sel.sv
// arb_mux_sel -- picks one W-bit field out of N packed per-master fields.
//   bus   : N fields, field i in bus[i*W +: W]
//   idx   : index of the field to select
//   field : selected field; zero when idx does not name a master
module arb_mux_sel
  import arb_mux_pkg::*;
#(
  parameter int N     = 2,
  parameter int W     = 32,
  parameter int IDX_W = id_width(N)
) (
  input  logic [N*W-1:0]   bus,
  input  logic [IDX_W-1:0] idx,
  output logic [W-1:0]     field
);

  // Compare-and-select rather than a variable part-select so an index
  // beyond N-1 yields zero instead of an out-of-range read.
  always_comb begin
    field = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == IDX_W'(i)) field = bus[i*W +: W];
    end
  end

endmodule

// File: rtl/arb_mux.sv
// arb_mux -- connects N_REQ masters to one slave through an external arbiter.
// One transaction at a time: the granted master's request is registered onto
// the slave channel, the response is returned as a one-cycle ack (or a
// one-cycle err when the slave takes too long), then the grant is released.
//   clk, rst            : clock, asynchronous active-high reset
//   m_req/m_we          : per-master request and write flag
//   m_addr/m_wdata      : packed per-master address / write data
//   m_ack/m_err         : one-cycle completion / timeout pulse to the master
//   m_rdata             : response data, valid with m_ack
//   arb_req             : requests forwarded to the arbiter
//   arb_gnt/arb_gnt_id  : arbiter grant-active and granted master index
//   s_valid/s_we/s_addr/s_wdata/s_ready : slave request channel
//   s_rsp_valid/s_rdata : slave response
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int  N_REQ   = 2,
  parameter int  ADDR_W  = 32,
  parameter int  DATA_W  = 32,
  parameter int  TIMEOUT = 255,
  localparam int ID_W    = id_width(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         m_req,
  input  logic [N_REQ-1:0]         m_we,
  input  logic [N_REQ*ADDR_W-1:0]  m_addr,
  input  logic [N_REQ*DATA_W-1:0]  m_wdata,
  output logic [N_REQ-1:0]         m_ack,
  output logic [N_REQ-1:0]         m_err,
  output logic [DATA_W-1:0]        m_rdata,
  output logic [N_REQ-1:0]         arb_req,
  input  logic                     arb_gnt,
  input  logic [ID_W-1:0]          arb_gnt_id,
  output logic                     s_valid,
  output logic                     s_we,
  output logic [ADDR_W-1:0]        s_addr,
  output logic [DATA_W-1:0]        s_wdata,
  input  logic                     s_ready,
  input  logic                     s_rsp_valid,
  input  logic [DATA_W-1:0]        s_rdata
);

  localparam int CNT_W = cnt_width(TIMEOUT);

  arb_mux_state_e    state, state_nx;
  logic [ID_W-1:0]   cur_id;
  logic [CNT_W-1:0]  cnt;
  logic              busy;
  logic              rsp_take;
  logic              tmo_hit;
  logic              err_take;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [N_REQ-1:0]  cur_oh;

  // Counter stops at TIMEOUT instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_W'(TIMEOUT)) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [N_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] oh;
    for (int i = 0; i < N_REQ; i++) oh[i] = (id == ID_W'(i));
    return oh;
  endfunction

  // Payload is taken from the master named by the grant itself, since
  // cur_id only holds that index from the following cycle.
  arb_mux_sel #(.N(N_REQ), .W(1), .IDX_W(ID_W)) u_sel_we (
    .bus   (m_we),
    .idx   (arb_gnt_id),
    .field (sel_we)
  );

  arb_mux_sel #(.N(N_REQ), .W(ADDR_W), .IDX_W(ID_W)) u_sel_addr (
    .bus   (m_addr),
    .idx   (arb_gnt_id),
    .field (sel_addr)
  );

  arb_mux_sel #(.N(N_REQ), .W(DATA_W), .IDX_W(ID_W)) u_sel_wdata (
    .bus   (m_wdata),
    .idx   (arb_gnt_id),
    .field (sel_wdata)
  );

  assign cur_oh   = id_onehot(cur_id);
  assign busy     = (state == ISSUE) || (state == WAIT_RSP);
  assign rsp_take = (state == WAIT_RSP) && s_rsp_valid;
  // The abort is decided in the cycle the counter steps onto TIMEOUT, so
  // the transaction spends at most TIMEOUT cycles in ISSUE plus WAIT_RSP.
  // A response arriving in that same cycle still completes normally.
  assign tmo_hit  = busy && (cnt == CNT_W'(TIMEOUT - 1));
  assign err_take = tmo_hit && !rsp_take;

  // While releasing, hide the finished master's request so the arbiter
  // does not re-grant it before the grant has dropped.
  always_comb begin
    arb_req = m_req;
    if (state == RELEASE) arb_req = m_req & ~cur_oh;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (arb_gnt) state_nx = ISSUE;
      ISSUE:    if (err_take) state_nx = RELEASE;
                else if (s_ready) state_nx = WAIT_RSP;
      WAIT_RSP: if (rsp_take || err_take) state_nx = RELEASE;
      RELEASE:  if (!arb_gnt) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_id  <= '0;
      cnt     <= '0;
      s_valid <= 1'b0;
      s_we    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      m_ack   <= '0;
      m_err   <= '0;
      m_rdata <= '0;
    end else begin
      m_ack   <= '0;
      m_err   <= '0;
      s_valid <= (state_nx == ISSUE);
      if (state == IDLE && arb_gnt) begin
        cur_id  <= arb_gnt_id;
        cnt     <= '0;
        s_we    <= sel_we;
        s_addr  <= sel_addr;
        s_wdata <= sel_wdata;
      end
      if (busy) cnt <= sat_inc(cnt);
      if (rsp_take) begin
        m_rdata <= s_rdata;
        m_ack   <= cur_oh;
      end
      if (err_take) m_err <= cur_oh;
    end
  end

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter N_REQ, default 2, number of requesting masters.
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 Parameter DATA_W, default 32, data width.
REQ-004 Parameter TIMEOUT, default 255, maximum cycles in ISSUE plus WAIT_RSP before abort.
REQ-005 Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  the single clock; all state updates on its rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 m_req  in  N_REQ  per-master request, held until m_ack or m_err.
REQ-009 m_we  in  N_REQ  per-master write flag.
REQ-010 m_addr  in  N_REQ*ADDR_W  packed per-master address; master i in slice [i*ADDR_W +: ADDR_W].
REQ-011 m_wdata  in  N_REQ*DATA_W  packed per-master write data.
REQ-012 m_ack  out  N_REQ  one-cycle completion pulse to the granted master.
REQ-013 m_err  out  N_REQ  one-cycle timeout pulse to the granted master.
REQ-014 m_rdata  out  DATA_W  response data, valid with m_ack.
REQ-015 arb_req  out  N_REQ  requests forwarded to the arbiter.
REQ-016 arb_gnt  in  1  arbiter grant-active.
REQ-017 arb_gnt_id  in  $clog2(N_REQ)  index of the granted master.
REQ-018 s_valid, s_we, s_addr, s_wdata  out  1/1/ADDR_W/DATA_W  slave request channel.
REQ-019 s_ready  in  1  slave accepts the request.
REQ-020 s_rsp_valid, s_rdata  in  1/DATA_W  slave response.

Function
REQ-021 States SHALL be IDLE, ISSUE, WAIT_RSP, RELEASE.
REQ-022 arb_req = m_req with bit cur_id forced to 0 while in RELEASE; combinational in all other cases.
REQ-023 IDLE: when arb_gnt=1, latch cur_id=arb_gnt_id, register s_we/s_addr/s_wdata from master cur_id, and go to ISSUE; s_valid=1 on the next cycle (one-cycle latency).
REQ-024 ISSUE: s_valid=1 with payload stable; on s_valid&s_ready, go to WAIT_RSP and drop s_valid in the next cycle.
REQ-025 WAIT_RSP: on s_rsp_valid, register m_rdata=s_rdata, pulse m_ack[cur_id] for exactly one cycle (the cycle after s_rsp_valid), and go to RELEASE.
REQ-026 Writes SHALL also wait for s_rsp_valid; m_rdata is then don't-care but registered identically.
REQ-027 RELEASE: hold until arb_gnt=0, then go to IDLE; IDLE SHALL NOT accept a grant in the same cycle it is entered.
REQ-028 Timeout counter: width $clog2(TIMEOUT+1), cleared on entry to ISSUE, increments each cycle in ISSUE/WAIT_RSP, saturates.
REQ-029 When the counter reaches TIMEOUT: drop s_valid, pulse m_err[cur_id] for one cycle (no m_ack), and go to RELEASE.
REQ-030 s_rsp_valid outside WAIT_RSP SHALL be ignored.
REQ-031 s_rsp_valid and timeout in the same cycle: the response wins (ack, no err).
REQ-032 m_req dropped mid-transaction: the transaction completes normally and ack/err is still pulsed.
REQ-033 m_ack and m_err SHALL be one-hot or zero and never both nonzero.

Reset
REQ-034 On rst: state=IDLE; cur_id, counter, s_valid, s_we, s_addr, s_wdata, m_ack, m_err, and m_rdata SHALL all be 0.
REQ-035 arb_req SHALL equal m_req during reset.
REQ-036 Reset mid-transaction SHALL abort silently, with no ack or err.

Structure
REQ-037 Package arb_mux_pkg SHALL hold the state enum typedef arb_mux_state_e.
REQ-038 One sub-module, arb_mux_sel: parameterised indexed slice-select of packed per-master fields, used for the addr, wdata, and we selects.

Verification
REQ-039 N_REQ=2, m_req=01, grant id 0 at cycle 0, s_ready=1, s_rsp_valid at cycle 3 with s_rdata=0xA5 -> s_valid at cycle 1, m_ack=01 and m_rdata=0xA5 at cycle 4, arb_req[0]=0 until arb_gnt falls.
REQ-040 Both masters request, grants 0 then 1 -> two transactions serialised, m_ack order 01 then 10, s_addr matches each master.
REQ-041 s_ready low for 5 cycles -> s_valid and payload held stable, then accepted; completion as normal.
REQ-042 TIMEOUT=8 with no response -> m_err pulses at cycle 9 after grant, s_valid=0, no m_ack, return to IDLE once arb_gnt=0.
REQ-043 rst asserted in WAIT_RSP -> all outputs 0 immediately (async); no ack after release; the next grant is served normally.
REQ-044 s_rsp_valid on the same cycle the counter hits TIMEOUT -> m_ack, no m_err.
